// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   - Baud divisor constants: bit period minus one, in clk cycles (50 MHz clock).
//   - Receiver FSM state type.
//   - half_minus_one(): reload value for the start-bit half-period timer.
package uart_rx_pkg;

    localparam logic [15:0] B115200 = 16'd433;
    localparam logic [15:0] B57600  = 16'd867;
    localparam logic [15:0] B19200  = 16'd2603;
    localparam logic [15:0] B9600   = 16'd5207;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // H = P>>1 with P = baud+1; the counter is loaded with H-1 so that the
    // start bit is sampled exactly H cycles after the falling edge.
    function automatic logic [15:0] half_minus_one(input logic [15:0] baud);
        logic [16:0] p;
        p = {1'b0, baud} + 17'd1;
        return 16'((p >> 1) - 17'd1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples rx at mid-bit, reassembles LSB-first bytes and
// holds each good byte in a valid/ready output register.
// Ports:
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   rx        in   asynchronous serial line, idle high
//   data      out  [7:0] received byte, meaningful while valid=1
//   valid     out  byte available, held until accepted
//   ready     in   consumer accepts data when valid && ready
//   frame_err out  1-cycle pulse when the stop bit samples 0
//   overrun   out  1-cycle pulse when a good byte is dropped (data still held)
//   busy      out  1 from start-edge detect until the stop sample completes
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter logic [15:0] BAUDRATE = B9600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] H_M1 = half_minus_one(BAUDRATE);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_s_d;
    logic [1:0]  sync_fill;
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        fall;
    logic        strobe;

    assign fall   = rx_s_d & ~rx_s;
    assign strobe = (state != ST_IDLE) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_d    <= 1'b0;
            sync_fill <= '0;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            // The two synchronizer stages still carry their reset value for
            // two cycles after release; the edge-history flop only follows
            // rx_s once it reflects the line, so a line held low across
            // reset never produces a false edge.
            sync_fill <= {sync_fill[0], 1'b1};
            rx_s_d    <= rx_s & sync_fill[1];

            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            // Counter runs only while a frame is in progress; each strobe
            // reloads a full bit period.
            if (state != ST_IDLE) begin
                cnt <= strobe ? BAUDRATE : cnt - 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt   <= H_M1;
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (strobe) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            // Also covers the same-cycle handshake: the
                            // accepted byte is replaced and valid stays high.
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with BAUDRATE=15 (P=16, H=8).
// A transaction-level reference model predicts every output cycle by cycle
// from frame start times; table vectors, hand-written sequences and random
// frames are applied against it.
module tb_uart_rx;

    localparam int P = 16;
    localparam int H = P / 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.BAUDRATE(16'd15)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {K_GOOD, K_BAD, K_GLITCH} kind_t;
    typedef struct {
        int         f;      // cycle in which the falling edge is detected
        int         e;      // cycle of the deciding sample (stop or false start)
        kind_t      kind;
        logic [7:0] b;
    } fr_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         glitch;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    fr_t        q[$];
    logic       m_valid = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         rand_ready = 1'b0;
    int         pulse_at = -1;
    bit         chk_on = 1'b0;
    bit         fe_seen = 1'b0;
    bit         ov_seen = 1'b0;
    int         v_rise = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] got[$];

    // Reference model: frame-level events mapped onto absolute cycles.
    always @(posedge clk) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
            m_busy  <= 1'b0;
            m_data  <= 8'h00;
            q.delete();
        end else begin
            m_fe <= 1'b0;
            m_ov <= 1'b0;
            if (m_valid && ready) m_valid <= 1'b0;
            if (q.size() != 0 && q[0].f == cyc) m_busy <= 1'b1;
            if (q.size() != 0 && q[0].e == cyc) begin
                m_busy <= 1'b0;
                if (q[0].kind == K_GOOD) begin
                    if (!m_valid || ready) begin
                        m_data  <= q[0].b;
                        m_valid <= 1'b1;
                    end else begin
                        m_ov <= 1'b1;
                    end
                end else if (q[0].kind == K_BAD) begin
                    m_fe <= 1'b1;
                end
                void'(q.pop_front());
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_on) begin
            checks++;
            if ({data, valid, frame_err, overrun, busy} !== {m_data, m_valid, m_fe, m_ov, m_busy}) begin
                errors++;
                $display("FAIL cycle %0d: got data=%02h valid=%b frame_err=%b overrun=%b busy=%b expected data=%02h valid=%b frame_err=%b overrun=%b busy=%b",
                         cyc, data, valid, frame_err, overrun, busy, m_data, m_valid, m_fe, m_ov, m_busy);
            end
        end
        if (frame_err) fe_seen = 1'b1;
        if (overrun) ov_seen = 1'b1;
        if (valid && !prev_valid) v_rise = cyc;
        prev_valid = valid;
        if (rand_ready) ready = ($urandom_range(0, 2) == 0);
        else if (pulse_at >= 0) ready = (cyc == pulse_at);
        if (valid && ready) got.push_back(data);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, input bit pulse_stop);
        logic [9:0] bits;
        fr_t r;
        bits   = {stop, b, 1'b0};
        r.f    = cyc + 2;
        r.e    = cyc + 2 + H + 9 * P;
        r.kind = stop ? K_GOOD : K_BAD;
        r.b    = b;
        q.push_back(r);
        if (pulse_stop) pulse_at = r.e;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (P) tick();
        end
        rx = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic send_glitch(input int len, input int gap);
        fr_t r;
        r.f    = cyc + 2;
        r.e    = cyc + 2 + H;
        r.kind = K_GLITCH;
        r.b    = 8'h00;
        q.push_back(r);
        rx = 1'b0;
        repeat (len) tick();
        rx = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic consume();
        if (valid) begin
            ready = 1'b1;
            tick();
            check("valid_clear", valid, 1'b0);
            ready = 1'b0;
            tick();
        end
    endtask

    initial begin
        vec_t       vecs[9];
        int         n0;
        int         sel;
        logic       stop;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 5, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 0, 1'b0, 8'hA5, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h55, 1'b1, 0, 1'b1, 8'h55, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 0, 1'b0, 8'h55, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 0, 1'b1, 8'h80, 1'b0};
        vecs[8] = '{8'h01, 1'b1, 0, 1'b1, 8'h01, 1'b0};

        rstn = 1'b0;
        repeat (3) tick();
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        chk_on = 1'b1;
        rstn = 1'b1;
        repeat (10) tick();

        // Table vectors: single frames or glitches with ready held low.
        for (int i = 0; i < 9; i++) begin
            fe_seen = 1'b0;
            ov_seen = 1'b0;
            v_rise  = -1;
            n0      = cyc;
            if (vecs[i].glitch != 0) send_glitch(vecs[i].glitch, 20);
            else send_frame(vecs[i].b, vecs[i].stop, 10, 1'b0);
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d_frame_err", i), fe_seen, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), ov_seen, 1'b0);
            if (i == 0) check("valid_latency", v_rise, n0 + 2 + H + 9 * P + 1);
            consume();
        end

        // Back-to-back with the first byte still held: second is dropped.
        ov_seen = 1'b0;
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 10, 1'b0);
        check("b2b_hold_data", data, 8'h11);
        check("b2b_hold_valid", valid, 1'b1);
        check("b2b_overrun", ov_seen, 1'b1);
        consume();

        // Same, but the consumer accepts in the stop-sample cycle.
        ov_seen = 1'b0;
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 10, 1'b1);
        pulse_at = -1;
        ready    = 1'b0;
        check("b2b_accept_data", data, 8'h22);
        check("b2b_accept_valid", valid, 1'b1);
        check("b2b_accept_overrun", ov_seen, 1'b0);
        consume();

        // Reset in the middle of a frame with the line held low after release.
        begin
            fr_t r;
            r.f    = cyc + 2;
            r.e    = cyc + 2 + H + 9 * P;
            r.kind = K_GOOD;
            r.b    = 8'h00;
            q.push_back(r);
        end
        rx = 1'b0;
        repeat (40) tick();
        check("midframe_busy", busy, 1'b1);
        rstn = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        rstn = 1'b1;
        fe_seen = 1'b0;
        repeat (40) tick();
        check("held_low_busy", busy, 1'b0);
        check("held_low_frame_err", fe_seen, 1'b0);
        rx = 1'b1;
        repeat (5) tick();
        send_frame(8'hFF, 1'b1, 10, 1'b0);
        check("after_rst_data", data, 8'hFF);
        check("after_rst_valid", valid, 1'b1);
        consume();

        // Loopback-style back-to-back stream with ready held high.
        got.delete();
        fe_seen = 1'b0;
        ov_seen = 1'b0;
        ready   = 1'b1;
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        send_frame(8'h55, 1'b1, 20, 1'b0);
        ready = 1'b0;
        check("loop_count", got.size(), 3);
        if (got.size() == 3) begin
            check("loop_byte0", got[0], 8'h00);
            check("loop_byte1", got[1], 8'hFF);
            check("loop_byte2", got[2], 8'h55);
        end
        check("loop_frame_err", fe_seen, 1'b0);
        check("loop_overrun", ov_seen, 1'b0);
        tick();

        // Random frames, bad stop bits, glitches and random ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                send_glitch(int'($urandom_range(1, 6)), 12 + int'($urandom_range(0, 8)));
            end else begin
                stop = (sel != 1);
                b    = 8'($urandom_range(0, 255));
                send_frame(b, stop, stop ? int'($urandom_range(0, 12)) : 3 + int'($urandom_range(0, 12)), 1'b0);
            end
        end
        repeat (200) tick();
        rand_ready = 1'b0;
        ready      = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
